// File: rtl/n_way_sum_using_fifos.sv
// n_way_sum_using_fifos: joins N_CHANNELS valid/ready streams, each buffered
// in its own FIFO, and pushes the widened sum of all heads into an output FIFO.
`timescale 1ns/1ps
module n_way_sum_using_fifos #(
    parameter int N_CHANNELS = 3,
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 16,
    localparam int SUM_W     = WIDTH + $clog2(N_CHANNELS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CHANNELS-1:0]       in_valid,
    output logic [N_CHANNELS-1:0]       in_ready,
    input  logic [N_CHANNELS*WIDTH-1:0] in_data,
    output logic                        sum_valid,
    input  logic                        sum_ready,
    output logic [SUM_W-1:0]            sum_data,
    output logic [CNT_W-1:0]            sum_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Input FIFO state, one slot per channel
    logic [N_CHANNELS-1:0][PW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [N_CHANNELS-1:0][CW-1:0] in_cnt_q, in_cnt_d;
    logic [WIDTH-1:0]              in_mem_q [N_CHANNELS][DEPTH];
    logic [N_CHANNELS-1:0]         in_full, in_empty, in_push;
    logic [N_CHANNELS-1:0][WIDTH-1:0] in_head;

    // Output FIFO state
    logic [PW-1:0]    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [CW-1:0]    out_cnt_q, out_cnt_d;
    logic [SUM_W-1:0] out_mem_q [DEPTH];
    logic             out_full, out_pop;

    logic             fire;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] sum_count_q, sum_count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status from registered state, join decision and next-state for every FIFO
    always_comb begin
        in_full   = '0;
        in_empty  = '0;
        in_push   = '0;
        in_head   = '0;
        in_wr_d   = in_wr_q;
        in_rd_d   = in_rd_q;
        in_cnt_d  = in_cnt_q;
        sum       = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            in_full[c]  = (in_cnt_q[c] == CW'(DEPTH));
            in_empty[c] = (in_cnt_q[c] == '0);
            in_head[c]  = in_mem_q[c][in_rd_q[c]];
            in_push[c]  = in_valid[c] && !in_full[c];
            sum         = sum + SUM_W'(in_head[c]);
        end
        out_full  = (out_cnt_q == CW'(DEPTH));
        sum_valid = (out_cnt_q != '0);
        in_ready  = ~in_full;
        // Registered out_full only: a same-cycle pop never unblocks the join
        fire      = (&(~in_empty)) && !out_full;
        out_pop   = sum_valid && sum_ready;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (in_push[c]) in_wr_d[c] = ptr_inc(in_wr_q[c]);
            if (fire)       in_rd_d[c] = ptr_inc(in_rd_q[c]);
            in_cnt_d[c] = in_cnt_q[c] + CW'(in_push[c]) - CW'(fire);
        end
        out_wr_d    = fire    ? ptr_inc(out_wr_q) : out_wr_q;
        out_rd_d    = out_pop ? ptr_inc(out_rd_q) : out_rd_q;
        out_cnt_d   = out_cnt_q + CW'(fire) - CW'(out_pop);
        sum_count_d = sum_count_q + CNT_W'(out_pop);
        // Storage is not reset, so mask the head while the FIFO is empty
        sum_data    = sum_valid ? out_mem_q[out_rd_q] : '0;
    end

    // Pointers, occupancy and counter; reset discards all buffered words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_wr_q     <= '0;
            in_rd_q     <= '0;
            in_cnt_q    <= '0;
            out_wr_q    <= '0;
            out_rd_q    <= '0;
            out_cnt_q   <= '0;
            sum_count_q <= '0;
        end else begin
            in_wr_q     <= in_wr_d;
            in_rd_q     <= in_rd_d;
            in_cnt_q    <= in_cnt_d;
            out_wr_q    <= out_wr_d;
            out_rd_q    <= out_rd_d;
            out_cnt_q   <= out_cnt_d;
            sum_count_q <= sum_count_d;
        end
    end

    // FIFO storage writes (data only, validity lives in the counts)
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CHANNELS; c++)
            if (in_push[c]) in_mem_q[c][in_wr_q[c]] <= in_data[c*WIDTH +: WIDTH];
        if (fire) out_mem_q[out_wr_q] <= sum;
    end

    assign sum_count = sum_count_q;
endmodule

// File: tb/tb_n_way_sum_using_fifos.sv
// tb_n_way_sum_using_fifos: directed plus random stimulus checked each cycle
// against a queue-based model of the N-way join.
`timescale 1ns/1ps
module tb_n_way_sum_using_fifos;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 16;
    localparam int SW = W + $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*W-1:0]  in_data;
    logic            sum_valid;
    logic            sum_ready;
    logic [SW-1:0]   sum_data;
    logic [CW-1:0]   sum_count;

    n_way_sum_using_fifos #(.N_CHANNELS(N), .WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .sum_data(sum_data), .sum_count(sum_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per channel plus the output queue
    int q_in[N][$];
    int q_out[$];
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) q_in[i].delete();
        q_out.delete();
        exp_cnt = 0;
    endtask

    task automatic check_state(input string tag);
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) er[i] = (q_in[i].size() < D);
        chk({tag, ".in_ready"},  64'(in_ready),  64'(er));
        chk({tag, ".sum_valid"}, 64'(sum_valid), 64'(q_out.size() > 0));
        chk({tag, ".sum_data"},  64'(sum_data),  (q_out.size() > 0) ? 64'(q_out[0]) : 64'd0);
        chk({tag, ".sum_count"}, 64'(sum_count), 64'(exp_cnt));
    endtask

    // One clock: drive inputs, advance model at the edge, compare after it
    task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic sr);
        bit pu[N];
        bit fire, pop;
        int s;
        in_valid  = v;
        in_data   = d;
        sum_ready = sr;
        fire = (q_out.size() < D);
        for (int i = 0; i < N; i++) begin
            if (q_in[i].size() == 0) fire = 0;
            pu[i] = v[i] && (q_in[i].size() < D);
        end
        pop = (q_out.size() > 0) && sr;
        @(posedge clk);
        if (pop) begin
            void'(q_out.pop_front());
            exp_cnt = (exp_cnt + 1) % (1 << CW);
        end
        if (fire) begin
            s = 0;
            for (int i = 0; i < N; i++) s += q_in[i].pop_front();
            q_out.push_back(s);
        end
        for (int i = 0; i < N; i++)
            if (pu[i]) q_in[i].push_back(int'(d[i*W +: W]));
        #1;
        check_state("cyc");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst = 1'b1; in_valid = '0; in_data = '0; sum_ready = 1'b0;
        model_clear();
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'h7);
        chk("reset_sum_valid", 64'(sum_valid), 64'd0);
        chk("reset_sum_count", 64'(sum_count), 64'd0);
        chk("reset_sum_data", 64'(sum_data), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check_state("post_reset");

        // Basic: 1+2+3 visible two edges after the push
        cyc(3'b111, {8'd3, 8'd2, 8'd1}, 1'b1);
        chk("basic_not_yet", 64'(sum_valid), 64'd0);
        cyc('0, '0, 1'b1);
        chk("basic_valid", 64'(sum_valid), 64'd1);
        chk("basic_sum", 64'(sum_data), 64'd6);
        cyc('0, '0, 1'b1);
        chk("basic_count", 64'(sum_count), 64'd1);

        // Max values, no truncation
        cyc(3'b111, {8'd255, 8'd255, 8'd255}, 1'b1);
        cyc('0, '0, 1'b0);
        chk("max_sum", 64'(sum_data), 64'd765);
        cyc('0, '0, 1'b1);

        // Skewed arrival on ch1
        cyc(3'b101, {8'd100, 8'd0, 8'd10}, 1'b1);
        cyc(3'b101, {8'd200, 8'd0, 8'd20}, 1'b1);
        cyc('0, '0, 1'b1);
        cyc('0, '0, 1'b1);
        chk("skew_wait", 64'(sum_valid), 64'd0);
        cyc(3'b010, {8'd0, 8'd1, 8'd0}, 1'b1);
        cyc('0, '0, 1'b1);
        chk("skew_first", 64'(sum_data), 64'd111);
        cyc('0, '0, 1'b1);
        cyc('0, '0, 1'b1);
        cyc(3'b010, {8'd0, 8'd2, 8'd0}, 1'b1);
        cyc('0, '0, 1'b1);
        chk("skew_second", 64'(sum_data), 64'd222);
        cyc('0, '0, 1'b1);

        // Backpressure: 8 triples fill output then input FIFOs
        c0 = exp_cnt;
        for (int k = 0; k < 8; k++) cyc(3'b111, (N*W)'($urandom), 1'b0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_sum_valid", 64'(sum_valid), 64'd1);
        for (int k = 0; k < 14; k++) cyc('0, '0, 1'b1);
        chk("bp_count", 64'(sum_count), 64'(c0 + 8));

        // Single empty channel stalls the join
        for (int k = 0; k < D; k++) cyc(3'b011, (N*W)'($urandom), 1'b1);
        chk("stall_in_ready", 64'(in_ready), 64'b100);
        chk("stall_sum_valid", 64'(sum_valid), 64'd0);
        c0 = exp_cnt;
        cyc(3'b100, (N*W)'($urandom), 1'b1);
        for (int k = 0; k < 4; k++) cyc('0, '0, 1'b1);
        chk("stall_one_sum", 64'(sum_count), 64'(c0 + 1));
        chk("stall_in_ready_after", 64'(in_ready), 64'b111);
        for (int k = 0; k < 3; k++) cyc(3'b100, (N*W)'($urandom), 1'b1);
        for (int k = 0; k < 6; k++) cyc('0, '0, 1'b1);

        // Async reset with 3 sums buffered
        for (int k = 0; k < 3; k++) cyc(3'b111, (N*W)'($urandom), 1'b0);
        cyc('0, '0, 1'b0);
        cyc('0, '0, 1'b0);
        chk("rst_buffered", 64'(sum_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_sum_valid", 64'(sum_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'h7);
        chk("rst_mid_count", 64'(sum_count), 64'd0);
        chk("rst_mid_sum_data", 64'(sum_data), 64'd0);
        model_clear();
        @(negedge clk) rst = 1'b0;
        cyc(3'b111, {8'd7, 8'd6, 8'd5}, 1'b1);
        cyc('0, '0, 1'b1);
        chk("rst_fresh_sum", 64'(sum_data), 64'd18);
        cyc('0, '0, 1'b1);

        // Random traffic against the model
        for (int k = 0; k < 400; k++)
            cyc(N'($urandom), (N*W)'($urandom), ($urandom_range(0, 3) != 0));
        for (int k = 0; k < 20; k++) cyc('0, '0, 1'b1);
        chk("drain_empty", 64'(sum_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
